// File: rtl/vid_timing_align.sv
// vid_timing_align
// Delays the display enables, syncs and HV trigger bus by a run-time
// programmable number of pixel ticks so they line up with a variable-latency
// pixel pipeline, and registers the final RGB.
// Optional build macro: VID_ALIGN_CURSOR_EN adds an HV-trigger test cursor
// overlay on the RGB output.

module vid_timing_align #(
  parameter int         MAX_DELAY = 16,
  parameter int         TRIG_W    = 48,
  parameter int         CW        = 8,
  parameter logic [3:0] PC_PHASE  = 4'd0,
  parameter int         DEF_DELAY = 11,
  parameter logic       SYNC_IDLE = 1'b1,
  localparam int        AW        = $clog2(MAX_DELAY)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [3:0]        pc_ena,
  input  logic              hde_in,
  input  logic              vde_in,
  input  logic              hs_in,
  input  logic              vs_in,
  input  logic [TRIG_W-1:0] HV_triggers_in,
  input  logic [AW-1:0]     delay_cfg,
  input  logic              delay_load,
  input  logic [CW-1:0]     red_in,
  input  logic [CW-1:0]     green_in,
  input  logic [CW-1:0]     blue_in,
  input  logic [TRIG_W-1:0] cursor_mask,
  input  logic [3*CW-1:0]   cursor_rgb,
  output logic              hde_out,
  output logic              vde_out,
  output logic              hs_out,
  output logic              vs_out,
  output logic [TRIG_W-1:0] HV_triggers_out,
  output logic [CW-1:0]     red,
  output logic [CW-1:0]     green,
  output logic [CW-1:0]     blue,
  output logic              aligned
);

  // Stored word layout: {hde, vde, hs, vs, HV triggers}
  localparam int WW = TRIG_W + 4;
  localparam int VS_BIT = TRIG_W;

  // Word presented while the outputs are blanked
  localparam logic [WW-1:0] BLANK_WORD = {2'b00, SYNC_IDLE, SYNC_IDLE, {TRIG_W{1'b0}}};

  typedef enum logic [1:0] {
    FILL = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t state, state_next;

  logic          tick;
  logic [WW-1:0] in_word;
  logic [WW-1:0] in_q;
  logic [WW-1:0] mem [MAX_DELAY];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [WW-1:0] rd_word;
  logic [WW-1:0] out_next;
  logic [AW-1:0] d_active, d_next;
  logic [AW-1:0] fill_cnt, fill_cnt_next;
  logic [AW-1:0] pend_val;
  logic          pend_valid;
  logic          vs_rise;
  logic          apply;
  logic          blanked;
  logic [CW-1:0] red_next, green_next, blue_next;

  // Clamp a requested delay into the supported range 2..MAX_DELAY-1
  function automatic logic [AW-1:0] clamp_delay(input logic [AW-1:0] req);
    logic [AW:0] wide;
    wide = {1'b0, req};
    if (wide < (AW+1)'(2))
      return AW'(2);
    else if (wide > (AW+1)'(MAX_DELAY - 1))
      return AW'(MAX_DELAY - 1);
    else
      return req;
  endfunction

  assign tick    = (pc_ena == PC_PHASE);
  assign in_word = {hde_in, vde_in, hs_in, vs_in, HV_triggers_in};

  // The previous tick's vs sample lives in in_q, so the edge is tick-sampled
  assign vs_rise = tick & vs_in & ~in_q[VS_BIT];

  assign rd_ptr   = wr_ptr - d_active;
  assign rd_word  = mem[rd_ptr];
  assign blanked  = (state == FILL);
  assign out_next = blanked ? BLANK_WORD : rd_word;
  assign aligned  = (state != FILL);

`ifdef VID_ALIGN_CURSOR_EN
  logic cur;
  assign cur        = |(out_next[TRIG_W-1:0] & cursor_mask);
  assign red_next   = red_in   | (cur ? cursor_rgb[3*CW-1:2*CW] : '0);
  assign green_next = green_in | (cur ? cursor_rgb[2*CW-1:CW]   : '0);
  assign blue_next  = blue_in  | (cur ? cursor_rgb[CW-1:0]      : '0);
`else
  logic unused_cursor;
  assign unused_cursor = ^{cursor_mask, cursor_rgb};
  assign red_next      = red_in;
  assign green_next    = green_in;
  assign blue_next     = blue_in;
`endif

  // Input sample register and write pointer advance once per pixel tick
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_q   <= BLANK_WORD;
      wr_ptr <= '0;
    end else if (tick) begin
      in_q   <= in_word;
      wr_ptr <= wr_ptr + AW'(1);
    end
  end

  // Circular delay buffer; never reset because blanking hides stale entries
  always_ff @(posedge clk) begin
    if (tick)
      mem[wr_ptr] <= in_q;
  end

  // A delay request is captured on any clock; the most recent one wins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_valid <= 1'b0;
      pend_val   <= AW'(DEF_DELAY);
    end else if (delay_load) begin
      pend_valid <= 1'b1;
      pend_val   <= clamp_delay(delay_cfg);
    end else if (apply) begin
      pend_valid <= 1'b0;
    end
  end

  // Control state, fill counter and the delay currently in force
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= FILL;
      fill_cnt <= '0;
      d_active <= AW'(DEF_DELAY);
    end else begin
      state    <= state_next;
      fill_cnt <= fill_cnt_next;
      d_active <= d_next;
    end
  end

  // Next-state logic: fill for D ticks, run, and swap delay on a vs rise
  always_comb begin
    state_next    = state;
    fill_cnt_next = fill_cnt;
    d_next        = d_active;
    apply         = 1'b0;
    if (tick) begin
      case (state)
        FILL: begin
          fill_cnt_next = fill_cnt + AW'(1);
          if (({1'b0, fill_cnt} + (AW+1)'(1)) == {1'b0, d_active})
            state_next = RUN;
        end
        RUN: begin
          if (pend_valid)
            state_next = PEND;
        end
        PEND: begin
          if (vs_rise) begin
            apply         = 1'b1;
            d_next        = pend_val;
            fill_cnt_next = '0;
            state_next    = FILL;
          end
        end
        default: begin
          state_next    = FILL;
          fill_cnt_next = '0;
        end
      endcase
    end
  end

  // Delayed timing output register, blanked while filling
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      {hde_out, vde_out, hs_out, vs_out, HV_triggers_out} <= BLANK_WORD;
    end else if (tick) begin
      {hde_out, vde_out, hs_out, vs_out, HV_triggers_out} <= out_next;
    end
  end

  // Pixel output register: one tick of latency, forced black while filling
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else if (tick) begin
      red   <= blanked ? '0 : red_next;
      green <= blanked ? '0 : green_next;
      blue  <= blanked ? '0 : blue_next;
    end
  end

endmodule

// File: tb/tb_vid_timing_align.sv
// tb_vid_timing_align
// Randomized timing/pixel stimulus with directed delay changes, compared
// against a tick-history reference model. Honors VID_ALIGN_CURSOR_EN.

module tb_vid_timing_align;

  localparam int         MAX_DELAY = 16;
  localparam int         TRIG_W    = 48;
  localparam int         CW        = 8;
  localparam logic [3:0] PC_PHASE  = 4'd0;
  localparam int         DEF_DELAY = 11;
  localparam logic       SYNC_IDLE = 1'b1;
  localparam int         AW        = 4;
  localparam int         WW        = TRIG_W + 4;

  localparam logic [WW-1:0] BLANK = {2'b00, SYNC_IDLE, SYNC_IDLE, {TRIG_W{1'b0}}};

  logic              clk = 1'b0;
  logic              reset_n;
  logic [3:0]        pc_ena;
  logic              hde_in, vde_in, hs_in, vs_in;
  logic [TRIG_W-1:0] HV_triggers_in;
  logic [AW-1:0]     delay_cfg;
  logic              delay_load;
  logic [CW-1:0]     red_in, green_in, blue_in;
  logic [TRIG_W-1:0] cursor_mask;
  logic [3*CW-1:0]   cursor_rgb;
  logic              hde_out, vde_out, hs_out, vs_out;
  logic [TRIG_W-1:0] HV_triggers_out;
  logic [CW-1:0]     red, green, blue;
  logic              aligned;

  // Free-running system clock
  always #5 clk = ~clk;

  vid_timing_align #(
    .MAX_DELAY (MAX_DELAY),
    .TRIG_W    (TRIG_W),
    .CW        (CW),
    .PC_PHASE  (PC_PHASE),
    .DEF_DELAY (DEF_DELAY),
    .SYNC_IDLE (SYNC_IDLE)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .pc_ena          (pc_ena),
    .hde_in          (hde_in),
    .vde_in          (vde_in),
    .hs_in           (hs_in),
    .vs_in           (vs_in),
    .HV_triggers_in  (HV_triggers_in),
    .delay_cfg       (delay_cfg),
    .delay_load      (delay_load),
    .red_in          (red_in),
    .green_in        (green_in),
    .blue_in         (blue_in),
    .cursor_mask     (cursor_mask),
    .cursor_rgb      (cursor_rgb),
    .hde_out         (hde_out),
    .vde_out         (vde_out),
    .hs_out          (hs_out),
    .vs_out          (vs_out),
    .HV_triggers_out (HV_triggers_out),
    .red             (red),
    .green           (green),
    .blue            (blue),
    .aligned         (aligned)
  );

  // Reference model: every tick's input word is kept; an output after tick k
  // is the word from tick k-D-1 unless k falls in the current fill window.
  logic [WW-1:0]   hist [0:4095];
  int              k;
  int              m_delay;
  int              fill_start;
  int              fill_end;
  int              pend_val;
  bit              pend_valid;
  bit              armed;
  logic [WW-1:0]   exp_word;
  logic [3*CW-1:0] exp_rgb;
  logic            exp_aligned;

  int pass_cnt;
  int check_cnt;

  function automatic int clamp_req(input int req);
    if (req < 2) return 2;
    if (req > MAX_DELAY - 1) return MAX_DELAY - 1;
    return req;
  endfunction

  task automatic model_reset();
    k          = 0;
    m_delay    = DEF_DELAY;
    fill_start = 1;
    fill_end   = DEF_DELAY;
    pend_valid = 1'b0;
    armed      = 1'b0;
    pend_val   = DEF_DELAY;
    hist[0]    = BLANK;
  endtask

  task automatic model_tick(input logic [WW-1:0] w, input logic [3*CW-1:0] rgb);
    bit   filling;
    bit   vs_rise;
    logic cur;
    k++;
    hist[k] = w;
    filling  = (k >= fill_start) && (k <= fill_end);
    exp_word = filling ? BLANK : hist[k - m_delay - 1];
    cur      = |(exp_word[TRIG_W-1:0] & cursor_mask);
`ifdef VID_ALIGN_CURSOR_EN
    exp_rgb = filling ? '0 : (rgb | (cur ? cursor_rgb : '0));
`else
    exp_rgb = filling ? '0 : rgb;
`endif
    vs_rise = w[TRIG_W] && !hist[k-1][TRIG_W];
    if (armed && vs_rise) begin
      m_delay    = pend_val;
      pend_valid = 1'b0;
      armed      = 1'b0;
      fill_start = k + 1;
      fill_end   = k + m_delay;
    end else if (!armed && !filling && pend_valid) begin
      armed = 1'b1;
    end
    exp_aligned = !(((k + 1) >= fill_start) && ((k + 1) <= fill_end));
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("[TB] FAIL %s tick=%0d observed=%h expected=%h", tag, k, obs, exp);
  endtask

  // One pixel tick (four clocks); delay_load pulses on clock load_phase (-1: none)
  task automatic applyStimulus(input logic vs, input int load_phase, input logic [AW-1:0] cfg);
    logic [WW-1:0]   w;
    logic [3*CW-1:0] rgb;
    w   = {1'($urandom()), 1'($urandom()), 1'($urandom()), vs,
           16'($urandom()), 32'($urandom())};
    rgb = 24'($urandom());
    {hde_in, vde_in, hs_in, vs_in, HV_triggers_in} = w;
    {red_in, green_in, blue_in} = rgb;
    delay_cfg = cfg;
    for (int p = 0; p < 4; p++) begin
      pc_ena     = PC_PHASE + 4'(p);
      delay_load = (p == load_phase);
      @(posedge clk);
      if (p == 0)
        model_tick(w, rgb);
      if (p == load_phase) begin
        pend_val   = clamp_req(int'(cfg));
        pend_valid = 1'b1;
      end
      #1;
      if (p == 0) begin
        checkOutput("timing", 64'({hde_out, vde_out, hs_out, vs_out, HV_triggers_out}), 64'(exp_word));
        checkOutput("rgb", 64'({red, green, blue}), 64'(exp_rgb));
        checkOutput("aligned", 64'(aligned), 64'(exp_aligned));
      end
    end
    delay_load = 1'b0;
  endtask

  task automatic vsPulse();
    applyStimulus(1'b1, -1, '0);
    applyStimulus(1'b0, -1, '0);
  endtask

  // Directed sequence of delay scenarios over random pixel/timing data
  initial begin
    pass_cnt       = 0;
    check_cnt      = 0;
    reset_n        = 1'b0;
    pc_ena         = 4'd1;
    delay_load     = 1'b0;
    delay_cfg      = '0;
    {hde_in, vde_in, hs_in, vs_in} = 4'b0000;
    HV_triggers_in = '0;
    {red_in, green_in, blue_in} = '0;
    cursor_mask    = 48'd1;
    cursor_rgb     = 24'hFF0000;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_timing", 64'({hde_out, vde_out, hs_out, vs_out, HV_triggers_out}), 64'(BLANK));
    checkOutput("reset_rgb", 64'({red, green, blue}), 64'd0);
    checkOutput("reset_aligned", 64'(aligned), 64'd0);
    reset_n = 1'b1;
    model_reset();

    $display("[TB] default delay fill and run");
    repeat (40) applyStimulus(1'b0, -1, '0);

    $display("[TB] delay 5 loaded mid-frame, applied at vs rise");
    applyStimulus(1'b0, 2, 4'd5);
    repeat (10) applyStimulus(1'b0, -1, '0);
    vsPulse();
    repeat (25) applyStimulus(1'b0, -1, '0);

    $display("[TB] delay 0 clamps to 2");
    applyStimulus(1'b0, 1, 4'd0);
    repeat (5) applyStimulus(1'b0, -1, '0);
    vsPulse();
    repeat (20) applyStimulus(1'b0, -1, '0);

    $display("[TB] maximum delay with pointer wrap");
    applyStimulus(1'b0, 3, 4'd15);
    repeat (3) applyStimulus(1'b0, -1, '0);
    vsPulse();
    repeat (50) applyStimulus(1'b0, -1, '0);

    $display("[TB] two loads before vs, latest wins");
    applyStimulus(1'b0, 1, 4'd7);
    repeat (2) applyStimulus(1'b0, -1, '0);
    applyStimulus(1'b0, 2, 4'd9);
    repeat (2) applyStimulus(1'b0, -1, '0);
    vsPulse();
    repeat (30) applyStimulus(1'b0, -1, '0);

    $display("[TB] load coincident with vs rise waits for next rise");
    applyStimulus(1'b1, 0, 4'd4);
    repeat (8) applyStimulus(1'b0, -1, '0);
    vsPulse();
    repeat (20) applyStimulus(1'b0, -1, '0);

    $display("[TB] asynchronous reset mid-frame");
    pc_ena = PC_PHASE + 4'd2;
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset_timing", 64'({hde_out, vde_out, hs_out, vs_out, HV_triggers_out}), 64'(BLANK));
    checkOutput("async_reset_rgb", 64'({red, green, blue}), 64'd0);
    checkOutput("async_reset_aligned", 64'(aligned), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    repeat (30) applyStimulus(1'b0, -1, '0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
